// File: rtl/lorentz_stream_tx.sv
// lorentz_stream_tx: decimating FIFO + framed byte serialiser for Lorentz x/y/z triples.
// Define LORENTZ_TX_CHK_EN to append an XOR checksum byte to every frame.
module lorentz_stream_tx #(
  parameter int DEPTH = 4,
  parameter int DECIM = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sample_valid,
  input  logic [63:0]              i_x_in,
  input  logic [63:0]              i_y_in,
  input  logic [63:0]              i_z_in,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [15:0]              o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CHK} state_t;
  state_t          r_state;
  logic [191:0]    r_shift;
  logic [4:0]      r_idx;
  logic [7:0]      r_data;
  logic            r_valid;
`ifdef LORENTZ_TX_CHK_EN
  logic [7:0]      r_acc;
`endif
  logic [191:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic [DW-1:0]   r_dcnt;
  logic [15:0]     r_drop;
  logic            w_hs, w_pop, w_cand, w_push;
  assign w_hs   = r_valid && i_tx_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
  assign w_cand = i_sample_valid && (r_dcnt == '0);
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push = w_cand && ((r_level != (AW+1)'(DEPTH)) || w_pop);
  assign o_tx_data    = r_data;
  assign o_tx_valid   = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_level = r_level;
  assign o_drop_count = r_drop;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_dcnt <= '0;
    else if (i_sample_valid)
      r_dcnt <= (r_dcnt == DW'(DECIM - 1)) ? '0 : r_dcnt + 1'b1;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= {i_x_in, i_y_in, i_z_in};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_cand && !w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef LORENTZ_TX_CHK_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_shift <= r_mem[r_rptr];
          r_data  <= 8'hA5;
          r_valid <= 1'b1;
          r_state <= S_SYNC;
`ifdef LORENTZ_TX_CHK_EN
          r_acc   <= '0;
`endif
        end
        S_SYNC: if (w_hs) begin
          r_data  <= r_shift[191:184];
          r_idx   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: if (w_hs) begin
          r_shift <= {r_shift[183:0], 8'h00};
          r_idx   <= r_idx + 1'b1;
`ifdef LORENTZ_TX_CHK_EN
          r_acc   <= r_acc ^ r_data;
`endif
          if (r_idx == 5'd23) begin
`ifdef LORENTZ_TX_CHK_EN
            r_data  <= r_acc ^ r_data;
            r_state <= S_CHK;
`else
            r_valid <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else
            r_data <= r_shift[183:176];
        end
        default: if (w_hs) begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
endmodule
